// File: rtl/change_dispenser.sv
// Change dispenser: pays out an owed coin count to the hopper one coin at a time
// over a fire/ack handshake, tracking hopper stock and latching a jam on ack timeout.
module change_dispenser #(
    parameter int CW         = 3,
    parameter int SW         = 8,
    parameter int STOCK_INIT = 20,
    parameter int ACK_TO     = 15,
    parameter int GAP        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [CW-1:0] change,
    output logic          coin_fire,
    input  logic          coin_ack,
    input  logic          refill,
    input  logic [SW-1:0] refill_cnt,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] owed,
    output logic [SW-1:0] stock,
    output logic          empty,
    output logic          jam
);

    localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FIRE  = 5'b00010,
        S_GAP   = 5'b00100,
        S_DONE  = 5'b01000,
        S_FAULT = 5'b10000
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] owed_q, owed_d;
    logic [SW-1:0] stock_q, stock_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          jam_q, jam_d;
    logic          coin_fire_q, coin_fire_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_ok;

    // Refill and a counted coin may land in the same cycle; the net change saturates at full scale.
    function automatic logic [SW-1:0] sat_stock(input logic [SW-1:0] cur,
                                                input logic [SW-1:0] add,
                                                input logic          dec);
        logic [SW:0] sum;
        sum = {1'b0, cur} + {1'b0, add};
        if (dec && (sum != '0))
            sum = sum - (SW+1)'(1);
        return sum[SW] ? {SW{1'b1}} : sum[SW-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        owed_d  = owed_q;
        jam_d   = jam_q;
        timer_d = '0;
        gap_d   = '0;
        ack_ok  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (change == '0) begin
                        state_d = S_DONE;
                    end else if (!jam_q) begin
                        owed_d  = change;
                        state_d = (stock_q == '0) ? S_FAULT : S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                // An ack arriving on the timeout cycle still counts as a coin.
                if (coin_ack) begin
                    ack_ok  = 1'b1;
                    owed_d  = owed_q - CW'(1);
                    state_d = (owed_q == CW'(1)) ? S_DONE : S_GAP;
                end else if (timer_q == TW'(ACK_TO - 1)) begin
                    jam_d   = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP - 1))
                    state_d = (stock_q == '0) ? S_FAULT : S_FIRE;
                else
                    gap_d = gap_q + GW'(1);
            end
            S_DONE: begin
                owed_d  = '0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (!jam_q && (stock_q != '0))
                    state_d = S_FIRE;
            end
            default: state_d = S_IDLE;
        endcase

        stock_d     = sat_stock(stock_q, refill ? refill_cnt : '0, ack_ok);
        coin_fire_d = (state_d == S_FIRE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owed_q      <= '0;
            stock_q     <= SW'(STOCK_INIT);
            timer_q     <= '0;
            gap_q       <= '0;
            jam_q       <= 1'b0;
            coin_fire_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owed_q      <= owed_d;
            stock_q     <= stock_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            jam_q       <= jam_d;
            coin_fire_q <= coin_fire_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign coin_fire = coin_fire_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign owed      = owed_q;
    assign stock     = stock_q;
    assign jam       = jam_q;
    assign empty     = (stock_q == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: stimulus pushes expected coin/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_change_dispenser;

    localparam int CW = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [CW-1:0] change;
    logic          coin_fire;
    logic          coin_ack;
    logic          hop_ack;
    logic          man_ack;
    logic          hop_en;
    logic          refill;
    logic [SW-1:0] refill_cnt;
    logic          busy, done, empty, jam;
    logic [CW-1:0] owed;
    logic [SW-1:0] stock;

    int compared   = 0;
    int mismatched = 0;

    typedef struct { int owed; int gap; } fire_t;
    typedef struct { int coins; int stock; } done_t;
    fire_t exp_fire[$];
    done_t exp_done[$];

    assign coin_ack = hop_ack | man_ack;

    change_dispenser #(.CW(CW), .SW(SW), .STOCK_INIT(20), .ACK_TO(15), .GAP(2)) dut (
        .clk(clk), .rst(rst), .req(req), .change(change),
        .coin_fire(coin_fire), .coin_ack(coin_ack),
        .refill(refill), .refill_cnt(refill_cnt),
        .busy(busy), .done(done), .owed(owed), .stock(stock),
        .empty(empty), .jam(jam)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input int c);
        req = 1'b1;
        change = CW'(c);
        tick(1);
        req = 1'b0;
        change = '0;
    endtask

    task automatic pulse_refill(input int c);
        refill = 1'b1;
        refill_cnt = SW'(c);
        tick(1);
        refill = 1'b0;
        refill_cnt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
        end
        @(posedge clk);
        #1;
    endtask

    // Queue a full request with automatic acks: coins owed c..1, GAP low cycles between coins.
    task automatic push_req(input int c, input int stock_after);
        for (int k = c; k >= 1; k--) begin
            fire_t f;
            f.owed = k;
            f.gap  = (k == c) ? 0 : 2;
            exp_fire.push_back(f);
        end
        begin
            done_t d;
            d.coins = c;
            d.stock = stock_after;
            exp_done.push_back(d);
        end
    endtask

    // Hopper model: acks two cycles after coin_fire rises, for one cycle.
    initial begin
        int age;
        age = 0;
        hop_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hop_ack) begin
                hop_ack = 1'b0;
                age = 0;
            end else if (coin_fire && hop_en) begin
                age++;
                if (age == 2) hop_ack = 1'b1;
            end else begin
                age = 0;
            end
        end
    end

    // Monitor
    initial begin
        bit    prev_fire;
        int    coins;
        int    low_cnt;
        fire_t fe;
        done_t de;
        prev_fire = 0;
        coins = 0;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_fire = 0;
                coins = 0;
                low_cnt = 0;
            end else begin
                if (coin_fire && !prev_fire) begin
                    coins++;
                    if (exp_fire.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_fire: coin_fire rose with owed=%0d, expected no coin", owed);
                    end else begin
                        fe = exp_fire.pop_front();
                        check("fire_owed", int'(owed), fe.owed);
                        if (fe.gap != 0) check("fire_gap", low_cnt, fe.gap);
                    end
                    low_cnt = 0;
                end else if (!coin_fire) begin
                    low_cnt++;
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_done: done pulse with stock=%0d, expected none", stock);
                    end else begin
                        de = exp_done.pop_front();
                        check("done_coins", coins, de.coins);
                        check("done_stock", int'(stock), de.stock);
                        check("done_owed", int'(owed), 0);
                    end
                    coins = 0;
                end
                prev_fire = coin_fire;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst = 1'b1; req = 1'b0; change = '0; man_ack = 1'b0; hop_en = 1'b1;
        refill = 1'b0; refill_cnt = '0;
        tick(3);
        check("rst_coin_fire", int'(coin_fire), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_owed", int'(owed), 0);
        check("rst_stock", int'(stock), 20);
        check("rst_jam", int'(jam), 0);
        check("rst_empty", int'(empty), 0);
        rst = 1'b0;
        tick(1);

        // 1: three coins with acks
        push_req(3, 17);
        pulse_req(3);
        check("t1_fire_latency", int'(coin_fire), 1);
        check("t1_busy", int'(busy), 1);
        wait_done("t1_done", 30);
        check("t1_done_width", int'(done), 0);
        tick(2);

        // 2: zero change
        push_req(0, 17);
        pulse_req(0);
        check("t2_no_fire", int'(coin_fire), 0);
        wait_done("t2_done", 4);
        check("t2_stock", int'(stock), 17);

        // 3: drain to one coin, run out mid-request, resume on refill
        do_reset();
        tick(1);
        push_req(7, 13); pulse_req(7); wait_done("t3_a", 60);
        push_req(7, 6);  pulse_req(7); wait_done("t3_b", 60);
        push_req(5, 1);  pulse_req(5); wait_done("t3_c", 60);
        check("t3_stock_one", int'(stock), 1);
        push_req(2, 4);
        exp_fire[$].gap = 0;
        pulse_req(2);
        tick(10);
        check("t3_fault_owed", int'(owed), 1);
        check("t3_fault_empty", int'(empty), 1);
        check("t3_fault_busy", int'(busy), 1);
        check("t3_fault_fire", int'(coin_fire), 0);
        pulse_refill(5);
        check("t3_refill_stock", int'(stock), 5);
        wait_done("t3_resume", 20);
        check("t3_final_stock", int'(stock), 4);
        tick(2);

        // 4: no ack -> jam after ACK_TO cycles of coin_fire
        hop_en = 1'b0;
        begin
            fire_t f;
            f.owed = 2;
            f.gap = 0;
            exp_fire.push_back(f);
        end
        pulse_req(2);
        hi = 0;
        while (coin_fire && hi < 40) begin
            hi++;
            tick(1);
        end
        check("t4_fire_cycles", hi, 15);
        check("t4_jam", int'(jam), 1);
        check("t4_owed", int'(owed), 2);
        check("t4_busy", int'(busy), 1);
        check("t4_stock", int'(stock), 4);
        pulse_req(1);
        tick(3);
        check("t4_req_ignored_fire", int'(coin_fire), 0);
        check("t4_req_ignored_owed", int'(owed), 2);
        check("t4_still_jam", int'(jam), 1);
        do_reset();
        check("t4_rst_jam", int'(jam), 0);
        check("t4_rst_stock", int'(stock), 20);
        check("t4_rst_busy", int'(busy), 0);
        check("t4_rst_owed", int'(owed), 0);

        // 5: refill saturation and refill+ack in one cycle
        tick(1);
        pulse_refill(250);
        check("t5_sat_a", int'(stock), 255);
        pulse_refill(10);
        check("t5_sat_b", int'(stock), 255);
        do_reset();
        tick(1);
        pulse_refill(80);
        check("t5_stock_100", int'(stock), 100);
        push_req(1, 102);
        pulse_req(1);
        man_ack = 1'b1;
        refill = 1'b1;
        refill_cnt = 8'd3;
        tick(1);
        man_ack = 1'b0;
        refill = 1'b0;
        refill_cnt = '0;
        check("t5_refill_ack", int'(stock), 102);
        check("t5_done", int'(done), 1);
        tick(3);

        // 6: req while busy and ack outside FIRE have no effect
        do_reset();
        hop_en = 1'b1;
        tick(1);
        push_req(2, 18);
        pulse_req(2);
        tick(2);
        man_ack = 1'b1;
        req = 1'b1;
        change = 3'd7;
        tick(1);
        man_ack = 1'b0;
        req = 1'b0;
        change = '0;
        check("t6_gap_owed", int'(owed), 1);
        check("t6_gap_stock", int'(stock), 19);
        wait_done("t6_done", 20);
        tick(2);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        tick(1);
        check("t6_idle_ack_stock", int'(stock), 18);
        check("t6_idle_owed", int'(owed), 0);
        check("t6_idle_fire", int'(coin_fire), 0);
        check("t6_idle_busy", int'(busy), 0);

        tick(3);
        check("fire_queue_drained", exp_fire.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
